// File: rtl/div_hilo_ctrl.sv
// Sequencer around a 32-cycle restoring divider: latches a DIV/DIVU request, sign-corrects the result into HI/LO.
// Optional signed support is built when DIV_HILO_SIGNED_EN is defined; otherwise every operation is unsigned.
module div_hilo_ctrl #(
  parameter int unsigned DIV_CYCLES = 33,
  parameter int unsigned TIMEOUT    = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        divStart,
  input  logic        divSigned,
  input  logic [31:0] rsData,
  input  logic [31:0] rtData,
  output logic        divReset,
  output logic        divCtrl,
  output logic [31:0] valueA,
  output logic [31:0] valueB,
  input  logic [31:0] quociente,
  input  logic [31:0] resto,
  input  logic        divEnd,
  output logic [31:0] hiOut,
  output logic [31:0] loOut,
  output logic        busy,
  output logic        done,
  output logic        divZeroExc,
  output logic        timeoutErr
);

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RUN, S_FIX, S_DONE, S_ZERO, S_ABORT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_run_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [W-1:0]     r_value_a;
  logic [W-1:0]     r_value_b;
  logic [W-1:0]     r_hi;
  logic [W-1:0]     r_lo;
  logic             r_div_reset;
  logic             r_div_ctrl;
  logic             r_busy;
  logic             r_done;
  logic             r_zero;
  logic             r_tmo;

  logic             w_neg_q;
  logic             w_neg_r;
  logic [W-1:0]     w_mag_a;
  logic [W-1:0]     w_mag_b;
  logic             w_div_reset;
  logic             w_div_ctrl;
  logic             w_busy;
  logic             w_done;
  logic             w_zero;
  logic             w_tmo;

`ifdef DIV_HILO_SIGNED_EN
  // Operand magnitudes and result signs; the most negative value maps onto itself.
  always_comb begin
    w_neg_r = divSigned & rsData[W-1];
    w_neg_q = divSigned & (rsData[W-1] ^ rtData[W-1]);
    w_mag_a = (divSigned && rsData[W-1]) ? W'(~rsData + W'(1)) : rsData;
    w_mag_b = (divSigned && rtData[W-1]) ? W'(~rtData + W'(1)) : rtData;
  end
`else
  logic w_unused_signed;
  assign w_unused_signed = divSigned;
  assign w_neg_r = 1'b0;
  assign w_neg_q = 1'b0;
  assign w_mag_a = rsData;
  assign w_mag_b = rtData;
`endif

  // Next state plus the values the registered outputs take on entry to it.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (divStart) w_next = S_CLEAR;
      S_CLEAR: w_next = (r_value_b == '0) ? S_ZERO : S_RUN;
      S_RUN: begin
        // Early divEnd is the divider's stale flag from the previous operation.
        if (divEnd && (r_run_cnt >= CNT_W'(DIV_CYCLES - 1)))
          w_next = S_FIX;
        else if (r_run_cnt == CNT_W'(TIMEOUT - 1))
          w_next = S_ABORT;
      end
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      S_ZERO:  w_next = S_IDLE;
      S_ABORT: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    w_div_reset = (w_next == S_CLEAR);
    w_div_ctrl  = (w_next == S_RUN);
    w_busy      = (w_next != S_IDLE);
    w_done      = (w_next == S_DONE) || (w_next == S_ZERO) || (w_next == S_ABORT);
    w_zero      = (w_next == S_ZERO);
    w_tmo       = (w_next == S_ABORT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_run_cnt   <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_value_a   <= '0;
      r_value_b   <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_div_reset <= 1'b1;
      r_div_ctrl  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_zero      <= 1'b0;
      r_tmo       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_div_reset <= w_div_reset;
      r_div_ctrl  <= w_div_ctrl;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_zero      <= w_zero;
      r_tmo       <= w_tmo;

      if (r_state == S_IDLE && divStart) begin
        r_value_a <= w_mag_a;
        r_value_b <= w_mag_b;
        r_neg_q   <= w_neg_q;
        r_neg_r   <= w_neg_r;
      end

      if (r_state == S_RUN) r_run_cnt <= r_run_cnt + CNT_W'(1);
      else                  r_run_cnt <= '0;

      if (r_state == S_FIX) begin
        r_lo <= r_neg_q ? W'(~quociente + W'(1)) : quociente;
        r_hi <= r_neg_r ? W'(~resto + W'(1))     : resto;
      end
    end
  end

  assign divReset   = r_div_reset;
  assign divCtrl    = r_div_ctrl;
  assign valueA     = r_value_a;
  assign valueB     = r_value_b;
  assign hiOut      = r_hi;
  assign loOut      = r_lo;
  assign busy       = r_busy;
  assign done       = r_done;
  assign divZeroExc = r_zero;
  assign timeoutErr = r_tmo;

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Scoreboard bench for div_hilo_ctrl with a behavioural divider stub and an arithmetic reference model.
module tb_div_hilo_ctrl;

  localparam int DIV_CYCLES = 33;
  localparam int TIMEOUT    = 40;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        divStart = 1'b0;
  logic        divSigned = 1'b0;
  logic [31:0] rsData = '0;
  logic [31:0] rtData = '0;
  logic        divReset, divCtrl;
  logic [31:0] valueA, valueB;
  logic [31:0] quociente, resto;
  logic        divEnd;
  logic [31:0] hiOut, loOut;
  logic        busy, done, divZeroExc, timeoutErr;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    bit          zero;
    bit          tmo;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] last_va, last_vb;

  // Divider stub: 32 enabled cycles, flag is not cleared by its reset.
  logic        st_end = 1'b1;
  logic [31:0] st_q = 32'hdead_beef;
  logic [31:0] st_r = 32'hcafe_f00d;
  int          st_cnt = 0;
  bit          hang = 1'b0;

  assign quociente = st_q;
  assign resto     = st_r;
  assign divEnd    = st_end;

  div_hilo_ctrl #(.DIV_CYCLES(DIV_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .divStart(divStart), .divSigned(divSigned),
    .rsData(rsData), .rtData(rtData), .divReset(divReset), .divCtrl(divCtrl),
    .valueA(valueA), .valueB(valueB), .quociente(quociente), .resto(resto),
    .divEnd(divEnd), .hiOut(hiOut), .loOut(loOut), .busy(busy), .done(done),
    .divZeroExc(divZeroExc), .timeoutErr(timeoutErr)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (divReset) begin
      st_cnt <= 0;
      st_q   <= $urandom;
      st_r   <= $urandom;
    end else if (divCtrl) begin
      st_cnt <= st_cnt + 1;
      if (st_cnt == 31 && !hang && valueB != 0) begin
        st_end <= 1'b1;
        st_q   <= valueA / valueB;
        st_r   <= valueA % valueB;
      end else if (st_cnt == 0 || hang) begin
        st_end <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: architectural result from plain 64-bit arithmetic.
  task automatic push_expect(input logic [31:0] rs, input logic [31:0] rt,
                             input bit sgn, input bit hng);
    exp_t   e;
    longint a, b, q, r;
    e.zero = (rt == 32'd0);
    e.tmo  = !e.zero && hng;
    if (e.zero || e.tmo) begin
      e.hi = m_hi;
      e.lo = m_lo;
    end else begin
      a = longint'({32'd0, rs});
      b = longint'({32'd0, rt});
`ifdef DIV_HILO_SIGNED_EN
      if (sgn) begin
        a = longint'($signed(rs));
        b = longint'($signed(rt));
      end
`endif
      q = a / b;
      r = a % b;
      e.lo = q[31:0];
      e.hi = r[31:0];
      m_hi = e.hi;
      m_lo = e.lo;
    end
    sb.push_back(e);
  endtask

  // Monitor: every done pulse pops one expectation.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pulse (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("hiOut", hiOut, e.hi);
        chk("loOut", loOut, e.lo);
        chk("divZeroExc", 32'(divZeroExc), 32'(e.zero));
        chk("timeoutErr", 32'(timeoutErr), 32'(e.tmo));
      end
    end
  end

  task automatic do_op(input logic [31:0] rs, input logic [31:0] rt, input bit sgn,
                       input bit hng, input int inject_k);
    int k, lat, nlow, ndr, ndc, exp_lat, exp_ctrl;
    hang = hng;
    @(negedge clock);
    divStart  = 1'b1;
    rsData    = rs;
    rtData    = rt;
    divSigned = sgn;
    push_expect(rs, rt, sgn, hng);
    @(posedge clock);
    #1 divStart = 1'b0;
    k = 0; lat = -1; nlow = 0; ndr = 0; ndc = 0;
    while (k < 200 && lat < 0) begin
      @(negedge clock);
      k++;
      if (k == inject_k) begin
        divStart  = 1'b1;
        rsData    = rs ^ 32'h0000_0055;
        rtData    = rt + 32'd3;
        divSigned = !sgn;
      end else begin
        divStart = 1'b0;
      end
      if (k == 1) begin
        last_va = valueA;
        last_vb = valueB;
      end
      if (divReset) ndr++;
      if (divCtrl)  ndc++;
      if (!busy)    nlow++;
      if (done)     lat = k;
    end
    exp_lat  = (rt == 0) ? 2 : (hng ? TIMEOUT + 2 : DIV_CYCLES + 3);
    exp_ctrl = (rt == 0) ? 0 : (hng ? TIMEOUT : DIV_CYCLES);
    chk("done_latency", 32'(lat), 32'(exp_lat));
    chk("busy_low_cycles", 32'(nlow), 32'd0);
    chk("divReset_cycles", 32'(ndr), 32'd1);
    chk("divCtrl_cycles", 32'(ndc), 32'(exp_ctrl));
    @(negedge clock);
    chk("busy_after_done", 32'(busy), 32'd0);
    hang = 1'b0;
  endtask

  initial begin
    logic [31:0] rs, rt;
    bit          sgn;
    int          sel;

    repeat (3) @(negedge clock);
    chk("rst_hiOut", hiOut, 32'd0);
    chk("rst_loOut", loOut, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_divCtrl", 32'(divCtrl), 32'd0);
    chk("rst_divReset", 32'(divReset), 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Unsigned 7/2
    do_op(32'd7, 32'd2, 1'b0, 1'b0, 0);

    // -7/2 with the sign request
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 0);
`ifdef DIV_HILO_SIGNED_EN
    chk("valueA_neg7", last_va, 32'd7);
`else
    chk("valueA_neg7", last_va, 32'hFFFF_FFF9);
`endif
    chk("valueB_2", last_vb, 32'd2);

    // Overflow corner
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);

    // Preload HI=5 LO=9, then divide by zero
    do_op(32'd68, 32'd7, 1'b0, 1'b0, 0);
    do_op(32'd1234, 32'd0, 1'b1, 1'b0, 0);

    // Start while busy is dropped
    do_op(32'd1000, 32'd13, 1'b0, 1'b0, 10);

    // Reset mid-run
    @(negedge clock);
    divStart = 1'b1; rsData = 32'd5000; rtData = 32'd3; divSigned = 1'b0;
    push_expect(32'd5000, 32'd3, 1'b0, 1'b0);
    @(posedge clock);
    #1 divStart = 1'b0;
    repeat (14) @(negedge clock);
    reset = 1'b1;
    void'(sb.pop_back());
    m_hi = '0;
    m_lo = '0;
    @(negedge clock);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_hiOut", hiOut, 32'd0);
    chk("midrst_loOut", loOut, 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_divCtrl", 32'(divCtrl), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    do_op(32'd100, 32'd7, 1'b0, 1'b0, 0);

    // Divider never finishes
    do_op(32'd77, 32'd5, 1'b0, 1'b1, 0);

    // Random operations
    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 9);
      rs  = $urandom;
      if (sel == 9) rs = 32'h8000_0000;
      case (sel)
        0:       rt = 32'd0;
        1, 2, 3: rt = 32'($urandom_range(1, 20));
        4:       rt = 32'hFFFF_FFFF;
        default: rt = $urandom;
      endcase
      sgn = 1'($urandom_range(0, 1));
      do_op(rs, rt, sgn, 1'b0, 0);
    end

    repeat (5) @(negedge clock);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/div_hilo_ctrl.md
Name: div_hilo_ctrl

Overview:
- Sequencing stage wrapped around the 32-cycle restoring divider.
- Accepts a DIV/DIVU request from the control unit and converts signed operands to magnitudes.
- Drives the divider's reset and enable, waits for completion, applies sign correction, and writes HI (remainder) and LO (quotient).
- Reports busy/done and a divide-by-zero exception back to the control unit.

Parameters:
- DIV_CYCLES, 33, minimum number of RUN cycles before divEnd is trusted; covers 32 iterations plus the end cycle.
- TIMEOUT, 40, number of RUN cycles after which the operation aborts if divEnd never rises.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- divStart  in  1  request pulse from the control unit.
- divSigned  in  1  1 = DIV, 0 = DIVU.
- rsData  in  32  dividend.
- rtData  in  32  divisor.
- divReset  out  1  reset to the divider.
- divCtrl  out  1  enable to the divider.
- valueA  out  32  dividend magnitude to the divider.
- valueB  out  32  divisor magnitude to the divider.
- quociente  in  32  quotient from the divider.
- resto  in  32  remainder from the divider.
- divEnd  in  1  completion flag from the divider.
- hiOut  out  32  HI register.
- loOut  out  32  LO register.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- divZeroExc  out  1  one-cycle divide-by-zero pulse.
- timeoutErr  out  1  one-cycle abort pulse.

Behaviour:
- Reset values: hiOut = loOut = 0, busy = done = divZeroExc = timeoutErr = divCtrl = 0, divReset = 1 while reset is high, state = IDLE.
- Reset is honoured in any state, including mid-operation. It aborts immediately, and HI/LO clear to 0.
- States: IDLE, CLEAR, RUN, FIX, DONE, ZERO, ABORT.
- IDLE:
  - divStart = 1 latches rsData, rtData, divSigned, plus sign flags: negQ = sign(rs) XOR sign(rt), negR = sign(rs), both forced to 0 when unsigned.
  - Moves to CLEAR.
  - divStart in any other state is ignored and not queued.
- CLEAR:
  - divReset = 1 for exactly one cycle.
  - valueA/valueB = magnitudes. Two's complement negate if signed and negative; 0x80000000 stays 0x80000000.
  - If the latched divisor == 0, go to ZERO; otherwise go to RUN.
- RUN:
  - divCtrl = 1 and run_cnt increments from 0.
  - Go to FIX when divEnd = 1 and run_cnt >= DIV_CYCLES-1.
  - Go to ABORT when run_cnt == TIMEOUT-1 without that condition.
  - divEnd before DIV_CYCLES-1 is ignored, because the divider's stale flag is not cleared by its reset.
- FIX:
  - divCtrl = 0.
  - loOut <= negQ ? -quociente : quociente.
  - hiOut <= negR ? -resto : resto.
  - Arithmetic is 32-bit modulo.
  - Go to DONE.
- DONE: done = 1 for one cycle, then IDLE.
- ZERO: divZeroExc = 1 and done = 1 for one cycle; HI/LO unchanged; then IDLE.
- ABORT: timeoutErr = 1 and done = 1 for one cycle; HI/LO unchanged; then IDLE.
- Latency with a divider that is on time: start edge E0 → CLEAR → RUN of DIV_CYCLES cycles → FIX → DONE. done is high in cycle E0 + DIV_CYCLES + 3.
- Overflow case 0x80000000 / 0xFFFFFFFF signed gives LO = 0x80000000, HI = 0. No exception is raised.
- valueA/valueB hold their values from CLEAR through FIX.
- HI/LO are written only in FIX.

Optional Feature:
- Macro: DIV_HILO_SIGNED_EN.
- Defined: divSigned is honoured as described above.
- Undefined:
  - divSigned is ignored and all operations are unsigned.
  - negQ = negR = 0 and the magnitude/negate logic is not synthesized.
  - -7/2 behaves as 0xFFFFFFF9/2.

Test Plan:
- Unsigned 7 / 2: rs = 7, rt = 2, divSigned = 0 → loOut = 3, hiOut = 1, done pulse at E0 + 36, busy high from E0 + 1 through E0 + 36.
- Signed -7 / 2 (macro on): rs = 0xFFFFFFF9, rt = 2, divSigned = 1 → valueA = 7, loOut = 0xFFFFFFFD, hiOut = 0xFFFFFFFF. With the macro off → loOut = 0x7FFFFFFC, hiOut = 1.
- Divide by zero: preload HI = 5, LO = 9; then rt = 0 → divZeroExc and done pulse at E0 + 2, divCtrl never asserted, HI/LO stay 5/9.
- Start while busy: second divStart at E0 + 10 with different operands → ignored; result matches the first operation; exactly one done pulse.
- Reset mid-run: assert reset at E0 + 15 → next cycle state is IDLE, hiOut = loOut = 0, busy = 0, no done pulse. A fresh 100 / 7 then gives LO = 14, HI = 2.
- Timeout: stub divider holds divEnd = 0 → timeoutErr and done pulse at E0 + TIMEOUT + 2, HI/LO unchanged, block returns to IDLE.
